// File: rtl/sdram_write_queue_pkg.sv
// sdram_write_queue_pkg
// Constants and types shared by the SDRAM write queue.
//   SDRAM_AW      : SDRAM byte-address width.
//   issue_state_t : request-issue FSM state encoding.
package sdram_write_queue_pkg;

  localparam int SDRAM_AW = 25;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } issue_state_t;

endpackage : sdram_write_queue_pkg

// File: rtl/sdram_write_queue_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a separate occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the
// same cycle. A pop of an empty FIFO is ignored.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push, data_in  : write request and its payload
//   pop            : remove the head entry
//   data_out       : head entry (valid while !empty)
//   full, empty    : occupancy flags
//   count          : current occupancy, 0..DEPTH
module sync_fifo
  import sdram_write_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH[PTR_W:0]);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // When full, the slot being written is the one being popped this cycle;
  // the read happens before the edge, so reuse is safe.
  assign do_push  = push & (~full | do_pop);
  assign data_out = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, and a resettable RAM cannot map to memory.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PTR_W bits, so they wrap modulo DEPTH naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/sdram_write_queue.sv
// sdram_write_queue
// Buffers byte writes from an upstream eraser/downloader and issues them
// one at a time to an SDRAM controller with a req/ack handshake.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   in_wr              : upstream write strobe (one write per cycle)
//   in_addr, in_data   : write address and byte, valid with in_wr
//   sd_req             : request to controller, held until sd_ack
//   sd_addr, sd_data   : current request, stable while sd_req is high
//   sd_ack             : one-cycle completion pulse from controller
//   busy               : queue non-empty or a request outstanding
//   count              : FIFO occupancy
//   overflow           : sticky, a write was dropped on a full FIFO
module sdram_write_queue
  import sdram_write_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = SDRAM_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_wr,
  input  logic [AW-1:0]          in_addr,
  input  logic [7:0]             in_data,
  output logic                   sd_req,
  output logic [AW-1:0]          sd_addr,
  output logic [7:0]             sd_data,
  input  logic                   sd_ack,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int ENTRY_W = AW + 8;

  issue_state_t       state;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  // A pop only happens from IDLE, so the next entry is taken no earlier
  // than the cycle after the ack that returned the FSM to IDLE.
  assign pop  = (state == IDLE) & ~fifo_empty;
  assign busy = (count != '0) | sd_req;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_wr),
    .data_in  ({in_addr, in_data}),
    .pop      (pop),
    .data_out (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  // Issue FSM with registered request outputs. A late ack arriving in IDLE
  // falls through the IDLE branch untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sd_req   <= 1'b0;
      sd_addr  <= '0;
      sd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_wr && fifo_full && !pop) begin
        overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            sd_addr <= head[ENTRY_W-1:8];
            sd_data <= head[7:0];
            sd_req  <= 1'b1;
            state   <= WAIT_ACK;
          end else begin
            sd_req  <= 1'b0;
          end
        end
        WAIT_ACK: begin
          if (sd_ack) begin
            sd_req <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          sd_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule : sdram_write_queue

// File: tb/tb_sdram_write_queue.sv
// tb_sdram_write_queue
// Directed self-checking bench for sdram_write_queue (DEPTH=8, AW=25).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_sdram_write_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 25;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_wr;
  logic [AW-1:0]          in_addr;
  logic [7:0]             in_data;
  logic                   sd_req;
  logic [AW-1:0]          sd_addr;
  logic [7:0]             sd_data;
  logic                   sd_ack;
  logic                   busy;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  int total = 0;
  int bad   = 0;
  int peak  = 0;

  sdram_write_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_wr    (in_wr),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .sd_req   (sd_req),
    .sd_addr  (sd_addr),
    .sd_data  (sd_data),
    .sd_ack   (sd_ack),
    .busy     (busy),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge; track peak occupancy.
  task automatic step();
    @(posedge clk);
    #1;
    if (int'(count) > peak) peak = int'(count);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    in_wr   = 1'b0;
    in_addr = '0;
    in_data = '0;
    sd_ack  = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_sd_req",   32'(sd_req),   32'd0);
    check("rst_sd_addr",  32'(sd_addr),  32'd0);
    check("rst_sd_data",  32'(sd_data),  32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single write, ack 3 cycles after sd_req rises
    in_wr = 1'b1; in_addr = 25'h1099A; in_data = 8'hFF;
    step();
    in_wr = 1'b0;
    check("single_count_after_push", 32'(count),  32'd1);
    check("single_req_not_yet",      32'(sd_req), 32'd0);
    check("single_busy_queued",      32'(busy),   32'd1);
    step();
    check("single_req_rise", 32'(sd_req),  32'd1);
    check("single_addr",     32'(sd_addr), 32'h1099A);
    check("single_data",     32'(sd_data), 32'hFF);
    check("single_popped",   32'(count),   32'd0);
    step();
    step();
    check("single_req_held",  32'(sd_req),  32'd1);
    check("single_addr_held", 32'(sd_addr), 32'h1099A);
    check("single_data_held", 32'(sd_data), 32'hFF);
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("single_req_clear", 32'(sd_req), 32'd0);
    check("single_busy_fall", 32'(busy),   32'd0);

    // Burst of 3, ack 2 cycles after each sd_req
    peak = 0;
    in_wr = 1'b1; in_addr = 25'h1099A; in_data = 8'hFF;
    step();
    check("b3_count1", 32'(count), 32'd1);
    in_addr = 25'h1099B;
    step();
    check("b3_req_a",  32'(sd_req),  32'd1);
    check("b3_addr_a", 32'(sd_addr), 32'h1099A);
    in_addr = 25'h1099C;
    step();
    in_wr = 1'b0;
    check("b3_count2",     32'(count),   32'd2);
    check("b3_addr_a_hld", 32'(sd_addr), 32'h1099A);
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("b3_req_gap1", 32'(sd_req), 32'd0);
    step();
    check("b3_req_b",  32'(sd_req),  32'd1);
    check("b3_addr_b", 32'(sd_addr), 32'h1099B);
    step();
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("b3_req_gap2", 32'(sd_req), 32'd0);
    step();
    check("b3_req_c",  32'(sd_req),  32'd1);
    check("b3_addr_c", 32'(sd_addr), 32'h1099C);
    check("b3_data_c", 32'(sd_data), 32'hFF);
    step();
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("b3_idle_busy", 32'(busy),     32'd0);
    check("b3_peak",      32'(peak),     32'd2);
    check("b3_overflow",  32'(overflow), 32'd0);

    // Burst of 10 with no ack: one issued, 8 queued, 10th dropped
    for (int i = 0; i < 10; i++) begin
      in_wr = 1'b1; in_addr = 25'h2000 + 25'(i); in_data = 8'(i);
      step();
    end
    in_wr = 1'b0;
    check("b10_req",      32'(sd_req),   32'd1);
    check("b10_addr",     32'(sd_addr),  32'h2000);
    check("b10_count",    32'(count),    32'd8);
    check("b10_overflow", 32'(overflow), 32'd1);
    step();
    check("b10_overflow_sticky", 32'(overflow), 32'd1);

    // Push on the pop cycle while full: accepted, count stays DEPTH
    do_reset();
    check("ovf_cleared_by_reset", 32'(overflow), 32'd0);
    for (int i = 0; i < 9; i++) begin
      in_wr = 1'b1; in_addr = 25'h4000 + 25'(i); in_data = 8'(8'h40 + i);
      step();
    end
    in_wr = 1'b0;
    check("full_count",    32'(count),    32'd8);
    check("full_overflow", 32'(overflow), 32'd0);
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("full_post_ack_req", 32'(sd_req), 32'd0);
    in_wr = 1'b1; in_addr = 25'h3000; in_data = 8'h55;
    step();
    in_wr = 1'b0;
    check("pp_count",    32'(count),    32'd8);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_addr",     32'(sd_addr),  32'h4001);
    check("pp_data",     32'(sd_data),  32'h41);
    // Drain and confirm arrival order, including the late-pushed entry
    for (int k = 0; k < 8; k++) begin
      sd_ack = 1'b1;
      step();
      sd_ack = 1'b0;
      step();
      check($sformatf("drain_addr_%0d", k), 32'(sd_addr),
            (k < 7) ? 32'h4002 + 32'(k) : 32'h3000);
    end
    check("drain_last_data", 32'(sd_data), 32'h55);
    check("drain_count",     32'(count),   32'd0);
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("drain_busy", 32'(busy), 32'd0);

    // Reset during WAIT_ACK with 4 queued, in_wr held through reset
    for (int i = 0; i < 5; i++) begin
      in_wr = 1'b1; in_addr = 25'h5000 + 25'(i); in_data = 8'(i);
      step();
    end
    check("rw_count4", 32'(count),  32'd4);
    check("rw_req",    32'(sd_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_wr = 1'b0;
    check("rw_req_dropped", 32'(sd_req), 32'd0);
    check("rw_count0",      32'(count),  32'd0);
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    step();
    check("rw_late_ack_req",   32'(sd_req), 32'd0);
    check("rw_late_ack_count", 32'(count),  32'd0);
    check("rw_late_ack_busy",  32'(busy),   32'd0);

    // Ack while idle and empty is ignored; queue still works afterwards
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    check("idle_ack_req",  32'(sd_req), 32'd0);
    check("idle_ack_busy", 32'(busy),   32'd0);
    in_wr = 1'b1; in_addr = 25'h1ABCDE; in_data = 8'h3C;
    step();
    in_wr = 1'b0;
    step();
    check("post_idle_ack_req",  32'(sd_req),  32'd1);
    check("post_idle_ack_addr", 32'(sd_addr), 32'h1ABCDE);
    check("post_idle_ack_data", 32'(sd_data), 32'h3C);
    step();
    check("no_ack_still_held", 32'(sd_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sdram_write_queue

// File: doc/sdram_write_queue.md
SDRAM_WRITE_QUEUE -- requirements
Module: sdram_write_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries (power of two, 2..64).
REQ-002 Parameter AW, default 25, SDRAM byte-address width.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_wr  in  1  write strobe from upstream eraser/downloader; one write per cycle while high.
REQ-006 in_addr  in  AW  write address, valid with in_wr.
REQ-007 in_data  in  8  write byte, valid with in_wr.
REQ-008 sd_req  out  1  write request to SDRAM controller; held until sd_ack.
REQ-009 sd_addr  out  AW  address of current request; stable while sd_req high.
REQ-010 sd_data  out  8  byte of current request; stable while sd_req high.
REQ-011 sd_ack  in  1  one-cycle pulse from controller: current write completed.
REQ-012 busy  out  1  high while FIFO non-empty or a request is outstanding; gates CPU RAM access.
REQ-013 count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  out  1  sticky: an in_wr was dropped because the FIFO was full.

Function
REQ-015 FIFO SHALL store {in_addr, in_data} on every cycle with in_wr high and (count < DEPTH or a pop occurs in the same cycle).
REQ-016 in_wr with count == DEPTH and no same-cycle pop SHALL drop the write and set overflow; overflow clears only on reset.
REQ-017 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL be a separate counter, +1 push, -1 pop, unchanged on simultaneous push and pop.
REQ-018 Issue FSM states: IDLE, WAIT_ACK.
REQ-019 IDLE with count > 0: pop head, register it into sd_addr/sd_data, set sd_req=1, go WAIT_ACK (same edge).
REQ-020 IDLE with count == 0: sd_req=0, remain IDLE.
REQ-021 WAIT_ACK: hold sd_req, sd_addr, sd_data; on sd_ack clear sd_req and return IDLE; the next pop occurs no earlier than the cycle after sd_ack.
REQ-022 sd_ack in IDLE SHALL be ignored.
REQ-023 Latency: in_wr at edge N into empty idle queue SHALL give sd_req=1 after edge N+1.
REQ-024 Writes SHALL reach the controller in exact arrival order; none duplicated.
REQ-025 busy = (count != 0) | sd_req, combinational from registered state.
REQ-026 Sustained throughput: one write per ack cycle pair (ack, next cycle pop); upstream bursts longer than DEPTH plus drain rate overflow by design.

Reset
REQ-027 On reset: pointers=0, count=0, state=IDLE, sd_req=0, sd_addr=0, sd_data=0, overflow=0.
REQ-028 Reset during WAIT_ACK SHALL drop the outstanding request (sd_req=0 after the reset edge) and discard all queued entries; a late sd_ack after reset is ignored per REQ-022.
REQ-029 in_wr during reset SHALL be ignored.

Structure
REQ-030 Shared package SHALL hold the SDRAM address width constant (25) and the FSM state encoding.
REQ-031 One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count), SHALL hold the storage; the FSM stays in sdram_write_queue.

Verification
REQ-032 Single write 0x1099A/0xFF into empty queue, ack 3 cycles after sd_req -> sd_req rises next cycle, sd_addr=0x1099A, sd_data=0xFF held until ack; busy falls the cycle after ack.
REQ-033 Burst of 3 consecutive in_wr (0x1099A..0x1099C, 0xFF), ack 2 cycles after each sd_req -> three requests in order, count peaks at 2, overflow=0.
REQ-034 Burst of 10 writes, DEPTH=8, no ack -> first write issued, 8 queued, 10th dropped, overflow=1, count=8.
REQ-035 count=DEPTH with in_wr on the pop cycle (post-ack IDLE) -> write accepted, count stays DEPTH, overflow=0.
REQ-036 Assert reset for 1 cycle while in WAIT_ACK with 4 queued, then pulse sd_ack -> sd_req=0, count=0, busy=0, no new request issued.
REQ-037 sd_ack pulsed while IDLE and empty -> no state change, sd_req stays 0.
